// File: rtl/x4xx_ctrlport_rr_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : x4xx_ctrlport_rr_arbiter
// Brief    : Round-robin sharing of one ctrlport slave among NUM_MASTERS
//            masters, one transaction outstanding. Optional macro
//            X4XX_CTRLPORT_ARB_TIMEOUT_EN adds a WAIT timeout (CMDERR reply).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module x4xx_ctrlport_rr_arbiter #(
   parameter int NUM_MASTERS    = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                           ctrlport_clk,
   input  logic                           ctrlport_rst,
   input  logic [NUM_MASTERS-1:0]         s_ctrlport_req_wr,
   input  logic [NUM_MASTERS-1:0]         s_ctrlport_req_rd,
   input  logic [20*NUM_MASTERS-1:0]      s_ctrlport_req_addr,
   input  logic [32*NUM_MASTERS-1:0]      s_ctrlport_req_data,
   input  logic [4*NUM_MASTERS-1:0]       s_ctrlport_req_byte_en,
   output logic [NUM_MASTERS-1:0]         s_ctrlport_resp_ack,
   output logic [2*NUM_MASTERS-1:0]       s_ctrlport_resp_status,
   output logic [32*NUM_MASTERS-1:0]      s_ctrlport_resp_data,
   output logic                           m_ctrlport_req_wr,
   output logic                           m_ctrlport_req_rd,
   output logic [19:0]                    m_ctrlport_req_addr,
   output logic [31:0]                    m_ctrlport_req_data,
   output logic [3:0]                     m_ctrlport_req_byte_en,
   input  logic                           m_ctrlport_resp_ack,
   input  logic [1:0]                     m_ctrlport_resp_status,
   input  logic [31:0]                    m_ctrlport_resp_data,
   output logic                           busy,
   output logic [$clog2(NUM_MASTERS)-1:0] grant_id
);

   localparam int                 c_grant_w    = $clog2(NUM_MASTERS);
   localparam logic [1:0]         c_st_idle    = 2'd0;
   localparam logic [1:0]         c_st_issue   = 2'd1;
   localparam logic [1:0]         c_st_wait    = 2'd2;
   localparam logic [1:0]         c_sts_cmderr = 2'b01;
   localparam logic [c_grant_w-1:0] c_last_init = c_grant_w'(NUM_MASTERS - 1);

   generate
      if (NUM_MASTERS < 2 || NUM_MASTERS > 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
         $error("x4xx_ctrlport_rr_arbiter: parameter out of range");
      end
   endgenerate

   logic [1:0]                  r_state;
   logic [c_grant_w-1:0]        r_grant_id;
   logic [c_grant_w-1:0]        r_last_grant;
   logic [NUM_MASTERS-1:0]      r_pending;
   logic [NUM_MASTERS-1:0]      r_req_wr;
   logic [NUM_MASTERS-1:0]      r_req_rd;
   logic [19:0]                 r_req_addr [NUM_MASTERS];
   logic [31:0]                 r_req_data [NUM_MASTERS];
   logic [3:0]                  r_req_be   [NUM_MASTERS];

   logic [NUM_MASTERS-1:0]      w_capture;
   logic [NUM_MASTERS-1:0]      w_above;
   logic [NUM_MASTERS-1:0]      w_hi_req;
   logic [NUM_MASTERS-1:0]      w_search;
   logic [c_grant_w-1:0]        w_sel;
   logic                        w_timeout;
   logic                        w_done;
   logic [1:0]                  w_done_sts;
   logic [31:0]                 w_done_dat;
   logic [NUM_MASTERS-1:0]      w_resp_ack;
   logic [2*NUM_MASTERS-1:0]    w_resp_sts;
   logic [32*NUM_MASTERS-1:0]   w_resp_dat;

`ifdef X4XX_CTRLPORT_ARB_TIMEOUT_EN
   localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES);
   logic [c_cnt_w-1:0] r_wait_cnt;

   always_ff @(posedge ctrlport_clk) begin
      if (ctrlport_rst || r_state == c_st_issue) begin
         r_wait_cnt <= '0;
      end else if (r_state == c_st_wait) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   // A downstream ack in the final cycle takes precedence over the timeout.
   assign w_timeout = (r_state == c_st_wait) && !m_ctrlport_resp_ack &&
                      (r_wait_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0;
`endif

   assign w_done     = (r_state == c_st_wait) && (m_ctrlport_resp_ack || w_timeout);
   assign w_done_sts = m_ctrlport_resp_ack ? m_ctrlport_resp_status : c_sts_cmderr;
   assign w_done_dat = m_ctrlport_resp_ack ? m_ctrlport_resp_data : 32'd0;

   always_comb begin
      w_resp_ack = '0;
      w_resp_sts = '0;
      w_resp_dat = '0;
      if (w_done) begin
         w_resp_ack[r_grant_id]            = 1'b1;
         w_resp_sts[2*r_grant_id +: 2]     = w_done_sts;
         w_resp_dat[32*r_grant_id +: 32]   = w_done_dat;
      end
   end

   // The master being answered may re-request on its own ack cycle.
   always_comb begin
      w_capture = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         w_capture[i] = (s_ctrlport_req_wr[i] || s_ctrlport_req_rd[i]) &&
                        (!r_pending[i] || w_resp_ack[i]);
      end
   end

   always_ff @(posedge ctrlport_clk) begin
      if (ctrlport_rst) begin
         r_pending <= '0;
         r_req_wr  <= '0;
         r_req_rd  <= '0;
         for (int i = 0; i < NUM_MASTERS; i++) begin
            r_req_addr[i] <= '0;
            r_req_data[i] <= '0;
            r_req_be[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_capture[i]) begin
               r_pending[i]  <= 1'b1;
               r_req_wr[i]   <= s_ctrlport_req_wr[i];
               r_req_rd[i]   <= s_ctrlport_req_rd[i];
               r_req_addr[i] <= s_ctrlport_req_addr[20*i +: 20];
               r_req_data[i] <= s_ctrlport_req_data[32*i +: 32];
               r_req_be[i]   <= s_ctrlport_req_byte_en[4*i +: 4];
            end else if (w_resp_ack[i]) begin
               r_pending[i]  <= 1'b0;
            end
         end
      end
   end

   // Prefer the lowest pending index above last_grant, else wrap to the lowest.
   always_comb begin
      w_above = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         w_above[i] = (i > int'(r_last_grant));
      end
      w_hi_req = r_pending & w_above;
      w_search = (|w_hi_req) ? w_hi_req : r_pending;
      w_sel    = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (w_search[i]) begin
            w_sel = i[c_grant_w-1:0];
         end
      end
   end

   always_ff @(posedge ctrlport_clk) begin
      if (ctrlport_rst) begin
         r_state                <= c_st_idle;
         r_grant_id             <= '0;
         r_last_grant           <= c_last_init;
         m_ctrlport_req_wr      <= 1'b0;
         m_ctrlport_req_rd      <= 1'b0;
         m_ctrlport_req_addr    <= '0;
         m_ctrlport_req_data    <= '0;
         m_ctrlport_req_byte_en <= '0;
         s_ctrlport_resp_ack    <= '0;
         s_ctrlport_resp_status <= '0;
         s_ctrlport_resp_data   <= '0;
      end else begin
         m_ctrlport_req_wr      <= 1'b0;
         m_ctrlport_req_rd      <= 1'b0;
         s_ctrlport_resp_ack    <= w_resp_ack;
         s_ctrlport_resp_status <= w_resp_sts;
         s_ctrlport_resp_data   <= w_resp_dat;
         case (r_state)
            c_st_idle: begin
               if (|r_pending) begin
                  r_grant_id             <= w_sel;
                  m_ctrlport_req_wr      <= r_req_wr[w_sel];
                  m_ctrlport_req_rd      <= r_req_rd[w_sel];
                  m_ctrlport_req_addr    <= r_req_addr[w_sel];
                  m_ctrlport_req_data    <= r_req_data[w_sel];
                  m_ctrlport_req_byte_en <= r_req_be[w_sel];
                  r_state                <= c_st_issue;
               end
            end
            c_st_issue: begin
               r_state <= c_st_wait;
            end
            c_st_wait: begin
               if (w_done) begin
                  r_last_grant <= r_grant_id;
                  r_state      <= c_st_idle;
               end
            end
            default: begin
               r_state <= c_st_idle;
            end
         endcase
      end
   end

   assign busy     = (r_state != c_st_idle);
   assign grant_id = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_x4xx_ctrlport_rr_arbiter.sv
`default_nettype none
// Testbench for x4xx_ctrlport_rr_arbiter: directed and random ctrlport traffic
// checked against a transaction-level round-robin model.
module tb_x4xx_ctrlport_rr_arbiter;

   localparam int N      = 4;
   localparam int TO_CYC = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    s_req_wr = '0;
   logic [N-1:0]    s_req_rd = '0;
   logic [20*N-1:0] s_req_addr = '0;
   logic [32*N-1:0] s_req_data = '0;
   logic [4*N-1:0]  s_req_be = '0;
   logic [N-1:0]    s_resp_ack;
   logic [2*N-1:0]  s_resp_status;
   logic [32*N-1:0] s_resp_data;
   logic            m_req_wr, m_req_rd;
   logic [19:0]     m_req_addr;
   logic [31:0]     m_req_data;
   logic [3:0]      m_req_be;
   logic            m_resp_ack = 1'b0;
   logic [1:0]      m_resp_status = '0;
   logic [31:0]     m_resp_data = '0;
   logic            busy;
   logic [1:0]      grant_id;

   x4xx_ctrlport_rr_arbiter #(
      .NUM_MASTERS   (N),
      .TIMEOUT_CYCLES(TO_CYC)
   ) dut (
      .ctrlport_clk          (clk),
      .ctrlport_rst          (rst),
      .s_ctrlport_req_wr     (s_req_wr),
      .s_ctrlport_req_rd     (s_req_rd),
      .s_ctrlport_req_addr   (s_req_addr),
      .s_ctrlport_req_data   (s_req_data),
      .s_ctrlport_req_byte_en(s_req_be),
      .s_ctrlport_resp_ack   (s_resp_ack),
      .s_ctrlport_resp_status(s_resp_status),
      .s_ctrlport_resp_data  (s_resp_data),
      .m_ctrlport_req_wr     (m_req_wr),
      .m_ctrlport_req_rd     (m_req_rd),
      .m_ctrlport_req_addr   (m_req_addr),
      .m_ctrlport_req_data   (m_req_data),
      .m_ctrlport_req_byte_en(m_req_be),
      .m_ctrlport_resp_ack   (m_resp_ack),
      .m_ctrlport_resp_status(m_resp_status),
      .m_ctrlport_resp_data  (m_resp_data),
      .busy                  (busy),
      .grant_id              (grant_id)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: one stored request per master plus the last served index.
   bit          mdl_pend [N];
   logic        mdl_wr   [N];
   logic        mdl_rd   [N];
   logic [19:0] mdl_addr [N];
   logic [31:0] mdl_data [N];
   logic [3:0]  mdl_be   [N];
   int          mdl_last;

   logic        drv_wr   [N];
   logic        drv_rd   [N];
   logic [19:0] drv_addr [N];
   logic [31:0] drv_data [N];
   logic [3:0]  drv_be   [N];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int mdl_next();
      for (int k = 1; k <= N; k++) begin
         if (mdl_pend[(mdl_last + k) % N]) return (mdl_last + k) % N;
      end
      return 0;
   endfunction

   function automatic bit mdl_any();
      for (int i = 0; i < N; i++) if (mdl_pend[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic mdl_reset();
      for (int i = 0; i < N; i++) mdl_pend[i] = 1'b0;
      mdl_last = N - 1;
   endtask

   task automatic set_req(input int m, input logic wr, input logic rd,
                          input logic [19:0] a, input logic [31:0] d, input logic [3:0] be);
      drv_wr[m] = wr; drv_rd[m] = rd; drv_addr[m] = a; drv_data[m] = d; drv_be[m] = be;
   endtask

   task automatic rand_fields();
      logic [31:0] r;
      for (int i = 0; i < N; i++) begin
         r = $urandom;
         drv_wr[i]   = r[0];
         drv_rd[i]   = r[0] ? r[1] : 1'b1;
         drv_addr[i] = r[31:12];
         drv_be[i]   = r[7:4];
         drv_data[i] = $urandom;
      end
   endtask

   // Drive strobes for the masked masters; the model keeps only non-pending ones.
   task automatic drive_inputs(input logic [N-1:0] mask);
      for (int i = 0; i < N; i++) begin
         if (mask[i]) begin
            s_req_wr[i]             = drv_wr[i];
            s_req_rd[i]             = drv_rd[i];
            s_req_addr[20*i +: 20]  = drv_addr[i];
            s_req_data[32*i +: 32]  = drv_data[i];
            s_req_be[4*i +: 4]      = drv_be[i];
            if (!mdl_pend[i]) begin
               mdl_pend[i] = 1'b1;
               mdl_wr[i] = drv_wr[i]; mdl_rd[i] = drv_rd[i];
               mdl_addr[i] = drv_addr[i]; mdl_data[i] = drv_data[i]; mdl_be[i] = drv_be[i];
            end
         end
      end
   endtask

   task automatic clear_inputs();
      s_req_wr = '0; s_req_rd = '0; s_req_addr = '0; s_req_data = '0; s_req_be = '0;
   endtask

   task automatic apply(input logic [N-1:0] mask);
      drive_inputs(mask);
      tick();
      clear_inputs();
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_m_wr"},    128'(m_req_wr), 128'(0));
      check({pfx, "_m_rd"},    128'(m_req_rd), 128'(0));
      check({pfx, "_m_addr"},  128'(m_req_addr), 128'(0));
      check({pfx, "_m_data"},  128'(m_req_data), 128'(0));
      check({pfx, "_m_be"},    128'(m_req_be), 128'(0));
      check({pfx, "_s_ack"},   128'(s_resp_ack), 128'(0));
      check({pfx, "_s_sts"},   128'(s_resp_status), 128'(0));
      check({pfx, "_s_data"},  128'(s_resp_data), 128'(0));
      check({pfx, "_busy"},    128'(busy), 128'(0));
      check({pfx, "_grant"},   128'(grant_id), 128'(0));
   endtask

   // Wait (bounded) for a downstream strobe and compare it with the model's pick.
   task automatic issue_next(output int m);
      int c;
      c = 0;
      while (!(m_req_wr || m_req_rd) && c < 30) begin
         tick();
         c++;
      end
      m = mdl_next();
      check("issue_seen",  128'(m_req_wr | m_req_rd), 128'(1));
      check("issue_grant", 128'(grant_id), 128'(m));
      check("issue_wr",    128'(m_req_wr), 128'(mdl_wr[m]));
      check("issue_rd",    128'(m_req_rd), 128'(mdl_rd[m]));
      check("issue_addr",  128'(m_req_addr), 128'(mdl_addr[m]));
      check("issue_data",  128'(m_req_data), 128'(mdl_data[m]));
      check("issue_be",    128'(m_req_be), 128'(mdl_be[m]));
   endtask

   // Act as the slave: ack after 'delay' cycles, optionally with new upstream strobes.
   task automatic respond(input int m, input logic [31:0] rdat, input logic [1:0] st,
                          input int delay, input logic [N-1:0] extra);
      tick();
      check("strobe_one_cycle", 128'({m_req_wr, m_req_rd}), 128'(0));
      for (int i = 1; i < delay; i++) tick();
      check("no_early_ack", 128'(s_resp_ack), 128'(0));
      m_resp_ack = 1'b1; m_resp_status = st; m_resp_data = rdat;
      mdl_pend[m] = 1'b0;
      mdl_last    = m;
      drive_inputs(extra);
      tick();
      m_resp_ack = 1'b0; m_resp_status = '0; m_resp_data = '0;
      clear_inputs();
      check("resp_ack",  128'(s_resp_ack), 128'(1) << m);
      check("resp_sts",  128'(s_resp_status), 128'(st) << (2 * m));
      check("resp_data", 128'(s_resp_data), 128'(rdat) << (32 * m));
      check("resp_idle", 128'(busy), 128'(0));
      tick();
      check("ack_one_cycle", 128'(s_resp_ack), 128'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          m;
      int          guard;
      logic [31:0] r;
      logic [N-1:0] mask;
      logic [N-1:0] ex;
      bit          seen;
      logic [31:0] rdv [N];

      mdl_reset();
      rand_fields();
      tick(); tick(); tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();

      // Single write from master 1 with 2-cycle issue latency.
      set_req(1, 1'b1, 1'b0, 20'h01004, 32'hDEADBEEF, 4'hF);
      drive_inputs(4'b0010);
      tick();
      clear_inputs();
      check("lat_e0_wr", 128'(m_req_wr), 128'(0));
      tick();
      check("lat_e1_wr", 128'(m_req_wr), 128'(1));
      issue_next(m);
      respond(m, 32'd0, 2'b00, 3, '0);

      // Simultaneous reads from 0, 2, 3: each read data returns only to its originator.
      rdv[0] = 32'h11; rdv[1] = 32'h0; rdv[2] = 32'h22; rdv[3] = 32'h33;
      rand_fields();
      for (int i = 0; i < N; i++) begin drv_wr[i] = 1'b0; drv_rd[i] = 1'b1; end
      apply(4'b1101);
      for (int k = 0; k < 3; k++) begin
         issue_next(m);
         respond(m, rdv[m], 2'b00, $urandom_range(1, 4), '0);
      end

      // Serve master 2, then 1 and 3 together: wrap-around fairness gives 3 then 1.
      rand_fields();
      apply(4'b0100);
      issue_next(m);
      respond(m, $urandom, 2'b00, 2, '0);
      rand_fields();
      apply(4'b1010);
      issue_next(m);
      check("wrap_first", 128'(grant_id), 128'(3));
      respond(m, $urandom, 2'b10, 1, '0);
      issue_next(m);
      check("wrap_second", 128'(grant_id), 128'(1));
      respond(m, $urandom, 2'b00, 2, '0);

      // Duplicate strobe while pending is ignored.
      set_req(0, 1'b0, 1'b1, 20'h02000, 32'h0, 4'h0);
      apply(4'b0001);
      set_req(0, 1'b0, 1'b1, 20'h02004, 32'h0, 4'h0);
      apply(4'b0001);
      issue_next(m);
      check("dup_addr", 128'(m_req_addr), 128'(20'h02000));
      respond(m, 32'h5A5A, 2'b00, 2, '0);
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (m_req_wr || m_req_rd || busy) seen = 1'b1;
         tick();
      end
      check("dup_no_reissue", 128'(seen), 128'(0));

      // Re-request from the served master on its own ack cycle, racing master 3.
      rand_fields();
      apply(4'b0100);
      issue_next(m);
      rand_fields();
      respond(m, $urandom, 2'b00, 2, 4'b1100);
      issue_next(m);
      check("own_ack_first", 128'(grant_id), 128'(3));
      respond(m, $urandom, 2'b00, 1, '0);
      issue_next(m);
      check("own_ack_second", 128'(grant_id), 128'(2));
      respond(m, $urandom, 2'b00, 1, '0);

      // Random batches with occasional duplicates and strobes during ack cycles.
      for (int b = 0; b < 30; b++) begin
         rand_fields();
         r = $urandom_range(1, 15);
         mask = r[N-1:0];
         apply(mask);
         if ($urandom_range(0, 1) == 1) begin
            rand_fields();
            apply(mask);
         end
         guard = 0;
         while (mdl_any() && guard < 40) begin
            issue_next(m);
            rand_fields();
            r  = $urandom;
            ex = (r[9:8] == 2'b00) ? r[N-1:0] : '0;
            respond(m, $urandom, r[13:12], $urandom_range(1, 5), ex);
            guard++;
         end
      end

      // Reset while waiting for the slave aborts the transaction.
      rand_fields();
      apply(4'b0110);
      issue_next(m);
      tick();
      tick();
      rst = 1'b1;
      tick();
      check_all_zero("mid_rst");
      rst = 1'b0;
      mdl_reset();
      m_resp_ack = 1'b1;
      m_resp_data = 32'hCAFEF00D;
      tick();
      m_resp_ack = 1'b0;
      m_resp_data = '0;
      check("late_ack_dropped", 128'(s_resp_ack), 128'(0));
      check("late_ack_data", 128'(s_resp_data), 128'(0));
      tick();
      check("late_ack_busy", 128'(busy), 128'(0));
      rand_fields();
      apply(4'b1011);
      issue_next(m);
      check("post_rst_first", 128'(grant_id), 128'(0));
      respond(m, $urandom, 2'b00, 1, '0);
      while (mdl_any()) begin
         issue_next(m);
         respond(m, $urandom, 2'b00, 2, '0);
      end

`ifdef X4XX_CTRLPORT_ARB_TIMEOUT_EN
      // Slave never acks: CMDERR after TIMEOUT_CYCLES in WAIT, then the next master.
      rand_fields();
      apply(4'b0011);
      issue_next(m);
      seen = 1'b0;
      for (int k = 0; k < TO_CYC; k++) begin
         tick();
         if (s_resp_ack != '0) seen = 1'b1;
      end
      check("to_early", 128'(seen), 128'(0));
      tick();
      check("to_ack",  128'(s_resp_ack), 128'(1) << m);
      check("to_sts",  128'(s_resp_status), 128'(2'b01) << (2 * m));
      check("to_data", 128'(s_resp_data), 128'(0));
      mdl_pend[m] = 1'b0;
      mdl_last    = m;
      issue_next(m);
      respond(m, $urandom, 2'b00, 2, '0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/x4xx_ctrlport_rr_arbiter.md
Name: x4xx_ctrlport_rr_arbiter

Overview:
- Shares one downstream ctrlport slave among NUM_MASTERS ctrlport masters, using round-robin arbitration with one transaction outstanding.
- Sits in the rfnoc_ctrl_clk domain in front of the motherboard register splitter, so the AXI-bridged ctrlport and fabric-side masters (e.g. application/PPS sequencers) can reach the same register space.
- Buffers one request per master, issues them in turn, and routes each response back to its originator.

Parameters:
- NUM_MASTERS, 4, number of upstream masters (2..16).
- TIMEOUT_CYCLES, 1024, cycles without downstream ack before an error response is returned (only used with the optional feature).

Ports:
- ctrlport_clk  in  1  clock.
- ctrlport_rst  in  1  synchronous, active-high reset.
- s_ctrlport_req_wr  in  NUM_MASTERS  per-master write strobe.
- s_ctrlport_req_rd  in  NUM_MASTERS  per-master read strobe.
- s_ctrlport_req_addr  in  20*NUM_MASTERS  address, master i at [20*i+:20].
- s_ctrlport_req_data  in  32*NUM_MASTERS  write data.
- s_ctrlport_req_byte_en  in  4*NUM_MASTERS  byte enables.
- s_ctrlport_resp_ack  out  NUM_MASTERS  per-master response strobe.
- s_ctrlport_resp_status  out  2*NUM_MASTERS  response status.
- s_ctrlport_resp_data  out  32*NUM_MASTERS  read data.
- m_ctrlport_req_wr  out  1  downstream write strobe.
- m_ctrlport_req_rd  out  1  downstream read strobe.
- m_ctrlport_req_addr  out  20  downstream address.
- m_ctrlport_req_data  out  32  downstream write data.
- m_ctrlport_req_byte_en  out  4  downstream byte enables.
- m_ctrlport_resp_ack  in  1  downstream ack.
- m_ctrlport_resp_status  in  2  downstream status.
- m_ctrlport_resp_data  in  32  downstream read data.
- busy  out  1  high whenever the FSM is not in IDLE.
- grant_id  out  clog2(NUM_MASTERS)  index of the current or most recent grant.

Behaviour:
- Interface: one clock (ctrlport_clk); reset ctrlport_rst is synchronous and active-high.
- Reset: all outputs 0; pending flags cleared; round-robin pointer last_grant = NUM_MASTERS-1, so master 0 has priority first; FSM = IDLE. Reset asserted mid-transaction aborts the transaction. No response is returned to the aborted master, and a later downstream ack for it is dropped.
- Capture: when s_req_wr[i] or s_req_rd[i] is sampled high and pending[i]=0, the block stores wr, rd, addr, data and byte_en for master i and sets pending[i].
  - A strobe while pending[i]=1 is a protocol violation: it is ignored and the stored request is kept.
  - wr and rd both high are stored and forwarded unchanged.
- FSM IDLE:
  - If any pending bit is set, select the first set bit searching from last_grant+1 upward, wrapping modulo NUM_MASTERS.
  - Register grant_id and move to ISSUE.
  - A pending bit captured on the same edge is not visible until the next cycle.
- FSM ISSUE:
  - m_req_wr/rd high for exactly one cycle, carrying the granted master's stored fields.
  - addr, data and byte_en hold their values until the next grant.
  - Go to WAIT.
- FSM WAIT:
  - On m_resp_ack, on the next cycle: s_resp_ack[grant_id]=1 for one cycle, with status and data registered from the downstream response.
  - On the ack edge, clear pending[grant_id], set last_grant=grant_id, return to IDLE.
  - m_resp_ack sampled in IDLE or ISSUE is ignored.
- Latency:
  - Request strobe at edge E0 → m_req strobe high in the cycle after E1, i.e. 2 cycles.
  - Downstream ack → upstream ack: 1 cycle.
  - Back-to-back grants: 2 idle cycles minimum between downstream strobes after an ack.
- Other masters' s_resp outputs stay 0. Resp data/status for non-acked masters are 0.
- A new request from the master just served may be captured on its own ack cycle. It then competes under round-robin with last_grant already updated.

Optional Feature:
- Macro: X4XX_CTRLPORT_ARB_TIMEOUT_EN.
- Defined:
  - A WAIT counter starts at 0 on entry to WAIT.
  - If the count reaches TIMEOUT_CYCLES-1 with no ack, the granted master receives s_resp_ack=1, status=2'b01 (CTRL_STS_CMDERR) and data=0.
  - pending is cleared and the FSM returns to IDLE.
  - An ack on the same cycle as the timeout wins: normal response, no error.
- Undefined: WAIT persists indefinitely and no counter is synthesised.

Test Plan:
- Single write from master 1 (addr 0x01004, data 0xDEADBEEF) → m_req_wr pulses 2 cycles later with those fields. Slave acks 3 cycles later → s_resp_ack[1] one cycle later, status 00, and no other ack bits set.
- Masters 0, 2 and 3 strobe reads in the same cycle after reset → downstream order 0, 2, 3. Each read data (0x11, 0x22, 0x33) is returned only to its originator.
- After master 2 is served, masters 1 and 3 request together → order 3, then 1 (wrap-around fairness).
- Duplicate strobe from master 0 while pending, with addr 0x2000 then 0x2004 → only 0x2000 is issued, with one response.
- With X4XX_CTRLPORT_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, the slave never acks → s_resp_ack with status 01 and data 0 arrives 16 cycles after entering WAIT. The next pending master is then issued.
- Assert ctrlport_rst in WAIT → all outputs 0 next cycle and busy=0. A late m_resp_ack produces no upstream ack, and the first request after reset goes to master 0 when it competes with others.
